mux_scan_ctrl: RTL and testbench

//  Sequencer wrapped around the 8:1 mux (mux_8X1). Drives the mux enable and
//  sel inputs, walks sel through every channel in order, and samples y for

---
 rtl/mux_scan_ctrl_if.sv | 25 ++
 rtl/mux_scan_ctrl.sv | 86 ++++++++
 tb/tb_mux_scan_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - bundle of the scan sequencer's mux-side and word-output signals
// master is the sequencer; slave is the mux/consumer side.
interface mux_scan_ctrl_if #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
);
  logic             start;
  logic             mux_y;
  logic             mux_enable;
  logic [SEL_W-1:0] mux_sel;
  logic [N_CH-1:0]  data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;

  modport master (
    input  start, mux_y, data_ready,
    output mux_enable, mux_sel, data_out, data_valid, busy
  );

  modport slave (
    output start, mux_y, data_ready,
    input  mux_enable, mux_sel, data_out, data_valid, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - walks an N_CH:1 mux select, samples y per channel, emits one word
// Each channel gets SETTLE idle cycles after sel changes before y is captured.
module mux_scan_ctrl #(
  parameter int N_CH   = 8,
  parameter int SEL_W  = 3,
  parameter int SETTLE = 1
) (
  input logic           clk,
  input logic           rst_n,
  mux_scan_ctrl_if.master bus
);

  localparam logic [1:0]       S_IDLE   = 2'd0;
  localparam logic [1:0]       S_SCAN   = 2'd1;
  localparam logic [1:0]       S_HOLD   = 2'd2;
  localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [SEL_W-1:0] sel;
  logic [N_CH-2:0]  shadow;
  logic [N_CH-1:0]  word;
  logic             valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sel    <= '0;
      shadow <= '0;
      word   <= '0;
      valid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_SCAN;
            sel   <= '0;
            cnt   <= '0;
          end
        end
        S_SCAN: begin
          if (cnt == SETTLE_C) begin
            cnt <= '0;
            // The last channel goes straight into the word; shadow only holds the rest.
            if (sel == LAST_SEL) begin
              word  <= {bus.mux_y, shadow};
              valid <= 1'b1;
              state <= S_HOLD;
              sel   <= '0;
            end else begin
              for (int i = 0; i < N_CH - 1; i++) begin
                if (sel == SEL_W'(i)) shadow[i] <= bus.mux_y;
              end
              sel <= sel + SEL_W'(1);
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_HOLD: begin
          if (bus.data_ready) begin
            valid <= 1'b0;
            state <= bus.start ? S_SCAN : S_IDLE;
            sel   <= '0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          sel   <= '0;
          cnt   <= '0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux_enable = (state == S_SCAN);
  assign bus.mux_sel    = sel;
  assign bus.data_out   = word;
  assign bus.data_valid = valid;
  assign bus.busy       = (state == S_SCAN) || (state == S_HOLD);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed bench for mux_scan_ctrl, SETTLE=1 and SETTLE=0 builds
// A timeline model predicts every output each cycle; directed steps pin literal values.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] a   [2];
  logic       st  [2];
  logic       rdy [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mux_scan_ctrl_if #(.N_CH(8), .SEL_W(3)) b1 ();
  mux_scan_ctrl_if #(.N_CH(8), .SEL_W(3)) b0 ();

  // The mux: y = a[sel] when enabled, else 0.
  assign b1.start      = st[0];
  assign b1.data_ready = rdy[0];
  assign b1.mux_y      = b1.mux_enable ? a[0][b1.mux_sel] : 1'b0;
  assign b0.start      = st[1];
  assign b0.data_ready = rdy[1];
  assign b0.mux_y      = b0.mux_enable ? a[1][b0.mux_sel] : 1'b0;

  mux_scan_ctrl #(.N_CH(8), .SEL_W(3), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mux_scan_ctrl #(.N_CH(8), .SEL_W(3), .SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  logic       dv  [2];
  logic [7:0] dout[2];
  logic       en  [2];
  logic [2:0] sl  [2];
  logic       bsy [2];
  assign dv[0] = b1.data_valid;  assign dv[1] = b0.data_valid;
  assign dout[0] = b1.data_out;  assign dout[1] = b0.data_out;
  assign en[0] = b1.mux_enable;  assign en[1] = b0.mux_enable;
  assign sl[0] = b1.mux_sel;     assign sl[1] = b0.mux_sel;
  assign bsy[0] = b1.busy;       assign bsy[1] = b0.busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 scanning, 2 holding; m_e counts edges since start was taken.
  int         m_mode [2];
  int         m_e    [2];
  logic [7:0] m_word [2];
  logic [7:0] m_out  [2];
  logic       m_valid[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_mode[d] = 0; m_e[d] = 0; m_word[d] = 8'h00; m_out[d] = 8'h00; m_valid[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin : step
        int per;
        int ch;
        per = (d == 0) ? 2 : 1;
        ch  = m_e[d] / per;
        if (m_mode[d] == 0) begin
          if (st[d]) begin m_mode[d] = 1; m_e[d] = 0; end
        end else if (m_mode[d] == 1) begin
          if ((m_e[d] + 1) % per == 0) begin
            m_word[d][ch] = a[d][ch];
            if (ch == 7) begin
              m_out[d] = m_word[d]; m_valid[d] = 1'b1; m_mode[d] = 2;
            end
          end
          m_e[d]++;
        end else if (rdy[d]) begin
          m_valid[d] = 1'b0;
          m_mode[d]  = st[d] ? 1 : 0;
          m_e[d]     = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      for (int d = 0; d < 2; d++) begin : cmp
        int per;
        logic [13:0] ev;
        logic [13:0] av;
        per = (d == 0) ? 2 : 1;
        ev = {m_mode[d] == 1, (m_mode[d] == 1) ? 3'(m_e[d] / per) : 3'd0,
              m_valid[d], m_out[d], m_mode[d] != 0};
        av = {en[d], sl[d], dv[d], dout[d], bsy[d]};
        check((d == 0) ? "model_settle1" : "model_settle0", 32'(av), 32'(ev));
      end
    end
  end

  task automatic scan_once(input int d, input logic [7:0] v, output int lat);
    a[d] = v; st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0; lat = 0;
    while (!dv[d] && lat < 100) begin @(negedge clk); lat++; end
  endtask

  int lat;
  int n;
  logic [7:0] v;
  logic [2:0] q[$];

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin a[d] = 8'h00; st[d] = 1'b0; rdy[d] = 1'b0; end
    #1;
    check("reset_state", 32'({en[0], sl[0], dout[0], dv[0], bsy[0]}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; chk_en = 1'b1;

    // 1: single word, consumer ready
    rdy[0] = 1'b1;
    scan_once(0, 8'h54, lat);
    check("t1_latency", 32'(lat), 32'd16);
    check("t1_data", 32'(dout[0]), 32'h54);
    check("t1_model_pin", 32'(m_out[0]), 32'h54);
    @(negedge clk);
    check("t1_one_cycle_valid", 32'({dv[0], bsy[0]}), 32'd0);

    // 2: consumer stalls for 20 cycles
    rdy[0] = 1'b0;
    scan_once(0, 8'h96, lat);
    check("t2_latency", 32'(lat), 32'd16);
    repeat (20) begin
      @(negedge clk);
      check("t2_hold", 32'({dv[0], en[0], dout[0]}), 32'h296);
    end
    rdy[0] = 1'b1;
    @(negedge clk);
    check("t2_release", 32'({dv[0], bsy[0]}), 32'd0);

    // 3: start held through scan and hold, then back-to-back
    rdy[0] = 1'b0; a[0] = 8'hA5; st[0] = 1'b1;
    @(negedge clk);
    q.delete(); n = 0;
    while (!dv[0] && n < 100) begin q.push_back(sl[0]); @(negedge clk); n++; end
    check("t3_scan_len", 32'(q.size()), 32'd16);
    for (int i = 0; i < q.size(); i++) check("t3_sel_seq", 32'(q[i]), 32'(i / 2));
    check("t3_data", 32'(dout[0]), 32'hA5);
    repeat (3) begin
      @(negedge clk);
      check("t3_no_rescan", 32'({dv[0], en[0]}), 32'b10);
    end
    rdy[0] = 1'b1;
    @(negedge clk);
    check("t3_back_to_back", 32'({dv[0], en[0], sl[0], bsy[0]}), 32'b010001);
    st[0] = 1'b0; a[0] = 8'h3A; n = 0;
    while (!dv[0] && n < 100) begin @(negedge clk); n++; end
    check("t3_b2b_latency", 32'(n), 32'd16);
    check("t3_b2b_data", 32'(dout[0]), 32'h3A);
    @(negedge clk);

    // 4: asynchronous reset mid-scan
    a[0] = 8'h3C; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0; n = 0;
    while (sl[0] != 3'd4 && n < 100) begin @(negedge clk); n++; end
    check("t4_reach_sel4", 32'(sl[0]), 32'd4);
    #2 rst_n = 1'b0;
    #1 check("t4_async_reset", 32'({en[0], sl[0], dout[0], dv[0], bsy[0]}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    scan_once(0, 8'h3C, lat);
    check("t4_after_reset_latency", 32'(lat), 32'd16);
    check("t4_after_reset_data", 32'(dout[0]), 32'h3C);
    @(negedge clk);

    // 5: input changes after channel 3 is sampled
    a[0] = 8'h00; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0; n = 0;
    while (sl[0] != 3'd4 && n < 100) begin @(negedge clk); n++; end
    check("t5_reach_sel4", 32'(sl[0]), 32'd4);
    a[0] = 8'hFF; n = 0;
    while (!dv[0] && n < 100) begin @(negedge clk); n++; end
    check("t5_data", 32'(dout[0]), 32'hF0);
    check("t5_model_pin", 32'(m_out[0]), 32'hF0);
    @(negedge clk);

    // 6: SETTLE=0 build, random words
    rdy[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      v = 8'($urandom);
      scan_once(1, v, lat);
      check("t6_latency", 32'(lat), 32'd8);
      check("t6_data", 32'(dout[1]), 32'(v));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
